// File: rtl/link_ctrl_sp_pkg.sv
// -----------------------------------------------------------------------------
// link_ctrl_sp_pkg
//   Symbols and state encoding shared by the link controller, its FIFO and
//   the Serial_Paralelo / Paralelo_Serial benches.
//   No ports (package).
// -----------------------------------------------------------------------------
package link_ctrl_sp_pkg;

    localparam logic [7:0] COM_SYM  = 8'hBC;   // comma / training symbol
    localparam logic [7:0] IDLE_SYM = 8'h7C;   // filler when no user data

    localparam int unsigned DEF_COM_COUNT  = 4;
    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_TRAIN  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERR    = 3'd4
    } link_state_e;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_sync_sp.sv
// -----------------------------------------------------------------------------
// fifo_sync_sp
//   Generic single-clock FIFO. Data at the head is presented combinationally
//   on o_rdata; a pop advances the head on the next clock edge.
//   Ports:
//     i_clk    clock
//     i_rst_n  asynchronous active-low reset (flushes the FIFO)
//     i_push   write i_wdata (ignored when full)
//     i_wdata  write data
//     i_pop    advance the head (ignored when empty)
//     o_rdata  head entry
//     o_full   no free entries
//     o_empty  no valid entries
// -----------------------------------------------------------------------------
module fifo_sync_sp #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/link_ctrl_sp.sv
// -----------------------------------------------------------------------------
// link_ctrl_sp
//   Transmit-side sequencer for the serial link into Serial_Paralelo.
//   Sends COM training until the far end reports active, then forwards
//   buffered user bytes (IDLE when nothing is buffered). Drops back to
//   training whenever active falls.
//   Ports:
//     clk_4f       byte-rate clock
//     reset        asynchronous active-low reset
//     data_in      user byte
//     valid_in     data_in valid; accepted when valid_in && ready_out
//     ready_out    buffer has room (low in RST)
//     rx_active    far-end active indication
//     tx_data      byte to the parallel-to-serial stage (registered)
//     tx_valid     tx_data meaningful (registered)
//     link_up      link is forwarding user data (registered)
//     timeout_err  sticky training failure, cleared once the link comes up
//     state        current FSM state
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_RST    | one cycle after reset release, nothing transmitted
//   ST_TRAIN  | send COM_COUNT commas unconditionally
//   ST_WAIT   | keep sending COM, wait for rx_active, bounded by TIMEOUT
//   ST_ACTIVE | forward FIFO bytes or IDLE; leave when rx_active drops
//   ST_ERR    | one cycle: send IDLE, flag timeout, retry training
// -----------------------------------------------------------------------------
module link_ctrl_sp
    import link_ctrl_sp_pkg::*;
#(
    parameter int unsigned COM_COUNT  = DEF_COM_COUNT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       rx_active,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       link_up,
    output logic       timeout_err,
    output logic [2:0] state
);

    localparam int unsigned CW = cnt_width(COM_COUNT);
    localparam int unsigned TW = cnt_width(TIMEOUT);

    localparam logic [CW-1:0] COM_LAST = CW'(COM_COUNT - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    link_state_e   r_state;
    link_state_e   w_state_nxt;
    logic [CW-1:0] r_com_cnt;
    logic [CW-1:0] w_com_cnt_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nxt;

    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    logic          r_tx_valid;
    logic          w_tx_valid_nxt;
    logic          r_link_up;
    logic          w_link_up_nxt;
    logic          r_timeout_err;
    logic          w_timeout_err_nxt;

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_fifo_head;

    // Pushes are accepted in every state but RST, including while training,
    // so the source can pre-load bytes before the link comes up.
    assign ready_out = !w_fifo_full && (r_state != ST_RST);
    assign w_push    = valid_in && ready_out;

    fifo_sync_sp #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (clk_4f),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_wdata (data_in),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RST;
            r_com_cnt     <= '0;
            r_to_cnt      <= '0;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_link_up     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_com_cnt     <= w_com_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_link_up     <= w_link_up_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    // The *_nxt outputs are the values launched at the next edge, so the
    // visible tx_data/tx_valid/link_up lag the state that produced them by
    // one cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_com_cnt_nxt     = r_com_cnt;
        w_to_cnt_nxt      = '0;
        w_tx_data_nxt     = 8'h00;
        w_tx_valid_nxt    = 1'b0;
        w_link_up_nxt     = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        w_pop             = 1'b0;

        case (r_state)
            ST_RST: begin
                w_com_cnt_nxt = '0;
                w_state_nxt   = ST_TRAIN;
            end

            ST_TRAIN: begin
                w_tx_data_nxt  = COM_SYM;
                w_tx_valid_nxt = 1'b1;
                if (r_com_cnt == COM_LAST) begin
                    w_com_cnt_nxt = '0;
                    w_state_nxt   = ST_WAIT;
                end else begin
                    w_com_cnt_nxt = r_com_cnt + 1'b1;
                end
            end

            ST_WAIT: begin
                w_tx_data_nxt  = COM_SYM;
                w_tx_valid_nxt = 1'b1;
                if (rx_active) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end

            ST_ERR: begin
                w_tx_data_nxt     = IDLE_SYM;
                w_tx_valid_nxt    = 1'b1;
                w_timeout_err_nxt = 1'b1;
                w_state_nxt       = ST_TRAIN;
            end

            ST_ACTIVE: begin
                w_tx_valid_nxt    = 1'b1;
                w_timeout_err_nxt = 1'b0;
                if (!rx_active) begin
                    // Exit cycle: keep buffered bytes for the next session
                    // and start training immediately on the wire.
                    w_tx_data_nxt = COM_SYM;
                    w_state_nxt   = ST_TRAIN;
                end else begin
                    w_link_up_nxt = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop         = 1'b1;
                        w_tx_data_nxt = w_fifo_head;
                    end else begin
                        w_tx_data_nxt = IDLE_SYM;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign link_up     = r_link_up;
    assign timeout_err = r_timeout_err;
    assign state       = r_state;

endmodule

// File: tb/tb_link_ctrl_sp.sv
module tb_link_ctrl_sp;
    import link_ctrl_sp_pkg::*;

    localparam int DEPTH = 4;

    logic       clk_4f    = 1'b0;
    logic       reset     = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic       valid_in  = 1'b0;
    logic       rx_active = 1'b0;
    logic       ready_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       link_up;
    logic       timeout_err;
    logic [2:0] state;

    link_ctrl_sp dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .rx_active   (rx_active),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .link_up     (link_up),
        .timeout_err (timeout_err),
        .state       (state)
    );

    always #5 clk_4f = ~clk_4f;

    int         errs   = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // User bytes are chosen distinct from COM/IDLE so any non-IDLE byte seen
    // while link_up is high must be the next scoreboard entry.
    task automatic monitor();
        logic [7:0] e;
        if (tx_valid && link_up && tx_data != IDLE_SYM) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_byte_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", {24'h0, tx_data}, {24'h0, e});
            end
        end
    endtask

    task automatic step();
        @(posedge clk_4f);
        @(negedge clk_4f);
        monitor();
    endtask

    task automatic send(input logic [7:0] d);
        data_in  = d;
        valid_in = 1'b1;
        chk("ready_out", {31'h0, ready_out}, {31'h0, (exp_q.size() < DEPTH)});
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state != st && n < budget) begin
            step();
            n++;
        end
        chk(tag, {29'h0, state}, {29'h0, st});
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        chk({pfx, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        chk({pfx, "_link_up"}, {31'h0, link_up}, 32'h0);
        chk({pfx, "_timeout_err"}, {31'h0, timeout_err}, 32'h0);
        chk({pfx, "_ready_out"}, {31'h0, ready_out}, 32'h0);
        chk({pfx, "_state"}, {29'h0, state}, {29'h0, ST_RST});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill [5];
        int n;
        fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // reset values
        #12;
        chk_reset_vals("rst");

        // training, wait and timeout
        @(negedge clk_4f);
        reset = 1'b1;
        step();
        chk("rst_exit_state", {29'h0, state}, {29'h0, ST_TRAIN});
        chk("rst_slot_txv", {31'h0, tx_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("train_com", {24'h0, tx_data}, {24'h0, COM_SYM});
            chk("train_txv", {31'h0, tx_valid}, 32'h1);
            chk("train_state", {29'h0, state}, (i == 3) ? {29'h0, ST_WAIT} : {29'h0, ST_TRAIN});
        end
        chk("train_ready", {31'h0, ready_out}, 32'h1);
        n = 0;
        while (state != ST_ERR && n < 200) begin
            chk("wait_com", {24'h0, tx_data}, {24'h0, COM_SYM});
            step();
            n++;
        end
        chk("wait_cycles", n, 64);
        step();
        chk("err_next_state", {29'h0, state}, {29'h0, ST_TRAIN});
        chk("err_idle", {24'h0, tx_data}, {24'h0, IDLE_SYM});
        chk("err_flag", {31'h0, timeout_err}, 32'h1);

        // activation from WAIT
        wait_state("reach_wait1", ST_WAIT, 20);
        step();
        step();
        rx_active = 1'b1;
        step();
        chk("enter_active", {29'h0, state}, {29'h0, ST_ACTIVE});
        chk("terr_hold", {31'h0, timeout_err}, 32'h1);
        step();
        chk("active_link_up", {31'h0, link_up}, 32'h1);
        chk("active_terr_clr", {31'h0, timeout_err}, 32'h0);
        chk("active_idle", {24'h0, tx_data}, {24'h0, IDLE_SYM});

        // three consecutive bytes, 2-cycle latency
        send(8'hA5);
        chk("lat_first_idle", {24'h0, tx_data}, {24'h0, IDLE_SYM});
        send(8'h3C);
        chk("lat_a5", {24'h0, tx_data}, 32'hA5);
        send(8'hFF);
        step();
        step();
        chk("drain_idle", {24'h0, tx_data}, {24'h0, IDLE_SYM});
        chk("sb_empty1", exp_q.size(), 0);

        // fill the buffer with the link down; fifth byte dropped
        rx_active = 1'b0;
        step();
        chk("exit_state", {29'h0, state}, {29'h0, ST_TRAIN});
        chk("exit_link_up", {31'h0, link_up}, 32'h0);
        chk("exit_com", {24'h0, tx_data}, {24'h0, COM_SYM});
        foreach (fill[k]) send(fill[k]);
        chk("full_ready", {31'h0, ready_out}, 32'h0);
        wait_state("reach_wait2", ST_WAIT, 20);
        rx_active = 1'b1;
        repeat (8) step();
        chk("sb_empty2", exp_q.size(), 0);
        chk("post_fill_idle", {24'h0, tx_data}, {24'h0, IDLE_SYM});

        // drop mid-stream with two bytes buffered
        send(8'h61);
        rx_active = 1'b0;
        send(8'h66);
        chk("mid_exit_state", {29'h0, state}, {29'h0, ST_TRAIN});
        chk("mid_exit_link_up", {31'h0, link_up}, 32'h0);
        step();
        chk("retrain_com", {24'h0, tx_data}, {24'h0, COM_SYM});
        wait_state("reach_wait3", ST_WAIT, 20);
        rx_active = 1'b1;
        repeat (6) step();
        chk("sb_empty3", exp_q.size(), 0);

        // single-cycle rx_active pulse in WAIT
        rx_active = 1'b0;
        step();
        wait_state("reach_wait4", ST_WAIT, 20);
        rx_active = 1'b1;
        step();
        chk("glitch_active", {29'h0, state}, {29'h0, ST_ACTIVE});
        rx_active = 1'b0;
        step();
        chk("glitch_exit", {29'h0, state}, {29'h0, ST_TRAIN});

        // reset mid-ACTIVE with a buffered byte
        wait_state("reach_wait5", ST_WAIT, 20);
        rx_active = 1'b1;
        step();
        step();
        send(8'h9A);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        rx_active = 1'b0;
        @(negedge clk_4f);
        reset = 1'b1;
        step();
        chk("midrst_train", {29'h0, state}, {29'h0, ST_TRAIN});
        wait_state("reach_wait6", ST_WAIT, 20);
        rx_active = 1'b1;
        repeat (5) step();
        chk("midrst_link_up", {31'h0, link_up}, 32'h1);
        chk("midrst_flushed_idle", {24'h0, tx_data}, {24'h0, IDLE_SYM});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
